// File: rtl/sc_reg_pkg.sv
// Shared constants for the SC_Reg register family: state encoding and default bus width.
package sc_reg_pkg;

    localparam int unsigned SC_REG_STATE_W       = 2;
    localparam int unsigned SC_REG_DEFAULT_WIDTH = 8;

    localparam logic [1:0] SC_REG_ST_IDLE    = 2'b00;
    localparam logic [1:0] SC_REG_ST_RUN     = 2'b01;
    localparam logic [1:0] SC_REG_ST_EXPIRED = 2'b10;

endpackage : sc_reg_pkg

// File: rtl/sc_edge_detect.sv
// Brings an asynchronous level into the clock domain and flags each rising edge for one cycle.
module sc_edge_detect (
    input  logic clk_i,
    input  logic rst_i,
    input  logic level_i,
    output logic rise_c_o
);

    logic sync1_q;
    logic sync2_q;
    logic stage3_q;

    // Two-flop synchronizer plus one history flop; history clears so a level already high after reset yields one edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stage3_q <= 1'b0;
        end else begin
            sync1_q  <= level_i;
            sync2_q  <= sync1_q;
            stage3_q <= sync2_q;
        end
    end

    assign rise_c_o = sync2_q & ~stage3_q;

endmodule : sc_edge_detect

// File: rtl/sc_reg_down_counter.sv
// Loadable down counter driven by an asynchronous decrement strobe; saturates at zero in EXPIRED.
module sc_reg_down_counter
    import sc_reg_pkg::*;
#(
    parameter int unsigned RegDOWN_DATAWIDTH = SC_REG_DEFAULT_WIDTH
) (
    input  logic                         SC_RegGENERAL_CLOCK_50,
    input  logic                         SC_RegGENERAL_RESET_InHigh,
    input  logic                         SC_RegDOWN_load_InHigh,
    input  logic [RegDOWN_DATAWIDTH-1:0] SC_RegDOWN_data_InBUS,
    input  logic                         SC_RegDOWN_dec_InHigh,
    input  logic                         SC_RegDOWN_hold_InHigh,
    output logic [RegDOWN_DATAWIDTH-1:0] SC_RegDOWN_data_OutBUS,
    output logic                         SC_RegDOWN_expired_OutHigh,
    output logic                         SC_RegDOWN_done_OutHigh
);

    logic [SC_REG_STATE_W-1:0]    state_q;
    logic [SC_REG_STATE_W-1:0]    state_d;
    logic [RegDOWN_DATAWIDTH-1:0] count_q;
    logic [RegDOWN_DATAWIDTH-1:0] count_d;
    logic                         done_q;
    logic                         done_d;
    logic                         expired_q;
    logic                         expired_d;
    logic                         dec_rise_c;

    sc_edge_detect u_dec_edge (
        .clk_i    (SC_RegGENERAL_CLOCK_50),
        .rst_i    (SC_RegGENERAL_RESET_InHigh),
        .level_i  (SC_RegDOWN_dec_InHigh),
        .rise_c_o (dec_rise_c)
    );

    always_ff @(posedge SC_RegGENERAL_CLOCK_50 or posedge SC_RegGENERAL_RESET_InHigh) begin
        if (SC_RegGENERAL_RESET_InHigh) begin
            state_q   <= SC_REG_ST_IDLE;
            count_q   <= '0;
            done_q    <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            done_q    <= done_d;
            expired_q <= expired_d;
        end
    end

    // Load beats any pending edge; the edge pulse is single-cycle so a dropped edge is simply lost.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        done_d  = 1'b0;

        if (SC_RegDOWN_load_InHigh) begin
            count_d = SC_RegDOWN_data_InBUS;
            state_d = (SC_RegDOWN_data_InBUS != '0) ? SC_REG_ST_RUN : SC_REG_ST_EXPIRED;
        end else begin
            case (state_q)
                SC_REG_ST_IDLE: begin
                    count_d = '0;
                end
                SC_REG_ST_RUN: begin
                    if (dec_rise_c && !SC_RegDOWN_hold_InHigh) begin
                        count_d = count_q - RegDOWN_DATAWIDTH'(1);
                        if (count_q == RegDOWN_DATAWIDTH'(1)) begin
                            state_d = SC_REG_ST_EXPIRED;
                            done_d  = 1'b1;
                        end
                    end
                end
                SC_REG_ST_EXPIRED: begin
                    count_d = '0;
                end
                default: begin
                    state_d = SC_REG_ST_IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    assign expired_d = (state_d == SC_REG_ST_EXPIRED);

    assign SC_RegDOWN_data_OutBUS     = count_q;
    assign SC_RegDOWN_expired_OutHigh = expired_q;
    assign SC_RegDOWN_done_OutHigh    = done_q;

endmodule : sc_reg_down_counter

// File: tb/tb_sc_reg_down_counter.sv
// Directed self-checking bench for sc_reg_down_counter at the default width and at width 4.
module tb_sc_reg_down_counter;

    logic       clk;
    logic       rst;

    logic       load8;
    logic [7:0] data8;
    logic       dec8;
    logic       hold8;
    logic [7:0] q8;
    logic       exp8;
    logic       done8;

    logic       load4;
    logic [3:0] data4;
    logic       dec4;
    logic       hold4;
    logic [3:0] q4;
    logic       exp4;
    logic       done4;

    int checks;
    int errors;
    int done_cnt8;
    int done_cnt4;
    int exp_done8;

    sc_reg_down_counter u_dut8 (
        .SC_RegGENERAL_CLOCK_50     (clk),
        .SC_RegGENERAL_RESET_InHigh (rst),
        .SC_RegDOWN_load_InHigh     (load8),
        .SC_RegDOWN_data_InBUS      (data8),
        .SC_RegDOWN_dec_InHigh      (dec8),
        .SC_RegDOWN_hold_InHigh     (hold8),
        .SC_RegDOWN_data_OutBUS     (q8),
        .SC_RegDOWN_expired_OutHigh (exp8),
        .SC_RegDOWN_done_OutHigh    (done8)
    );

    sc_reg_down_counter #(.RegDOWN_DATAWIDTH(4)) u_dut4 (
        .SC_RegGENERAL_CLOCK_50     (clk),
        .SC_RegGENERAL_RESET_InHigh (rst),
        .SC_RegDOWN_load_InHigh     (load4),
        .SC_RegDOWN_data_InBUS      (data4),
        .SC_RegDOWN_dec_InHigh      (dec4),
        .SC_RegDOWN_hold_InHigh     (hold4),
        .SC_RegDOWN_data_OutBUS     (q4),
        .SC_RegDOWN_expired_OutHigh (exp4),
        .SC_RegDOWN_done_OutHigh    (done4)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Count done cycles as seen at each rising edge; a proper pulse adds exactly one.
    always @(posedge clk) begin
        if (done8) done_cnt8 <= done_cnt8 + 1;
        if (done4) done_cnt4 <= done_cnt4 + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse8();
        dec8 = 1'b1;
        tick(4);
        dec8 = 1'b0;
        tick(4);
    endtask

    task automatic pulse4();
        dec4 = 1'b1;
        tick(4);
        dec4 = 1'b0;
        tick(4);
    endtask

    task automatic load_8(input logic [7:0] v);
        load8 = 1'b1;
        data8 = v;
        tick(1);
        load8 = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        done_cnt8 = 0;
        done_cnt4 = 0;
        exp_done8 = 0;
        rst   = 1'b1;
        load8 = 1'b0; data8 = '0; dec8 = 1'b0; hold8 = 1'b0;
        load4 = 1'b0; data4 = '0; dec4 = 1'b0; hold4 = 1'b0;

        // Reset state
        tick(3);
        check("rst_count", 32'(q8), 32'd0);
        check("rst_expired", 32'(exp8), 32'd0);
        check("rst_done", 32'(done8), 32'd0);
        rst = 1'b0;
        tick(2);

        // Load 3, count down to expiry with a single done pulse
        load_8(8'd3);
        check("load3_count", 32'(q8), 32'd3);
        check("load3_expired", 32'(exp8), 32'd0);
        pulse8();
        check("dec_to_2", 32'(q8), 32'd2);
        pulse8();
        check("dec_to_1", 32'(q8), 32'd1);
        dec8 = 1'b1;
        tick(2);
        check("pre_edge3_count", 32'(q8), 32'd1);
        check("pre_edge3_done", 32'(done8), 32'd0);
        tick(1);
        check("edge3_count", 32'(q8), 32'd0);
        check("edge3_done", 32'(done8), 32'd1);
        check("edge3_expired", 32'(exp8), 32'd1);
        tick(1);
        check("done_falls", 32'(done8), 32'd0);
        dec8 = 1'b0;
        tick(4);
        exp_done8 = 1;
        check("done_single", 32'(done_cnt8), 32'(exp_done8));

        // EXPIRED ignores further edges, no wrap
        for (int i = 0; i < 5; i++) pulse8();
        check("expired_hold_count", 32'(q8), 32'd0);
        check("expired_hold_flag", 32'(exp8), 32'd1);
        check("expired_no_done", 32'(done_cnt8), 32'(exp_done8));

        // Reset with dec already high; the post-reset edge reaches a freshly loaded RUN
        dec8 = 1'b1;
        rst  = 1'b1;
        tick(2);
        check("rst2_count", 32'(q8), 32'd0);
        check("rst2_expired", 32'(exp8), 32'd0);
        rst = 1'b0;
        load_8(8'd2);
        tick(2);
        check("post_rst_edge", 32'(q8), 32'd1);
        tick(3);
        check("post_rst_one_edge", 32'(q8), 32'd1);
        dec8 = 1'b0;
        tick(4);

        // Load 0 from IDLE goes straight to EXPIRED, no done
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(1);
        pulse8();
        check("idle_ignores", 32'(q8), 32'd0);
        check("idle_not_expired", 32'(exp8), 32'd0);
        load_8(8'd0);
        check("load0_count", 32'(q8), 32'd0);
        check("load0_expired", 32'(exp8), 32'd1);
        tick(2);
        check("load0_no_done", 32'(done_cnt8), 32'(exp_done8));

        // Load wins over a simultaneous edge
        load_8(8'd6);
        pulse8();
        check("count5", 32'(q8), 32'd5);
        dec8 = 1'b1;
        tick(2);
        load8 = 1'b1;
        data8 = 8'd9;
        tick(1);
        load8 = 1'b0;
        check("load_priority", 32'(q8), 32'd9);
        tick(1);
        dec8 = 1'b0;
        tick(4);
        check("load_priority_hold", 32'(q8), 32'd9);

        // Hold drops edges rather than queueing them
        load_8(8'd2);
        hold8 = 1'b1;
        pulse8();
        pulse8();
        check("hold_count", 32'(q8), 32'd2);
        hold8 = 1'b0;
        tick(2);
        check("hold_no_queue", 32'(q8), 32'd2);
        pulse8();
        check("hold_release", 32'(q8), 32'd1);
        pulse8();
        exp_done8++;
        check("hold_expire", 32'(exp8), 32'd1);
        check("hold_expire_done", 32'(done_cnt8), 32'(exp_done8));

        // Asynchronous reset mid-count abandons the count
        load_8(8'd200);
        for (int i = 0; i < 10; i++) pulse8();
        check("count190", 32'(q8), 32'd190);
        dec8 = 1'b1;
        tick(2);
        @(posedge clk);
        #5;
        rst = 1'b1;
        #1;
        check("async_rst_count", 32'(q8), 32'd0);
        check("async_rst_expired", 32'(exp8), 32'd0);
        check("async_rst_done", 32'(done8), 32'd0);
        tick(2);
        dec8 = 1'b0;
        rst  = 1'b0;
        tick(6);
        check("async_rst_idle", 32'(q8), 32'd0);
        check("async_rst_no_done", 32'(done_cnt8), 32'(exp_done8));

        // Width 4: all-ones load takes 15 edges, then saturates
        load4 = 1'b1;
        data4 = 4'hF;
        tick(1);
        load4 = 1'b0;
        check("w4_load", 32'(q4), 32'd15);
        for (int i = 0; i < 14; i++) pulse4();
        check("w4_after14", 32'(q4), 32'd1);
        check("w4_after14_exp", 32'(exp4), 32'd0);
        pulse4();
        check("w4_after15", 32'(q4), 32'd0);
        check("w4_after15_exp", 32'(exp4), 32'd1);
        check("w4_done", 32'(done_cnt4), 32'd1);
        pulse4();
        check("w4_no_wrap", 32'(q4), 32'd0);
        check("w4_done_once", 32'(done_cnt4), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_sc_reg_down_counter

// File: doc/sc_reg_down_counter.md
SC_REG_DOWN_COUNTER -- requirements
Module: sc_reg_down_counter

Interface
REQ-001 The block SHALL expose parameter RegDOWN_DATAWIDTH, default 8, giving the counter/bus width in bits.
REQ-002 The block SHALL have port SC_RegGENERAL_CLOCK_50, input, 1, system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port SC_RegGENERAL_RESET_InHigh, input, 1, reset; asynchronous, active-high.
REQ-004 The block SHALL have port SC_RegDOWN_load_InHigh, input, 1, synchronous parallel-load strobe.
REQ-005 The block SHALL have port SC_RegDOWN_data_InBUS, input, RegDOWN_DATAWIDTH, load value.
REQ-006 The block SHALL have port SC_RegDOWN_dec_InHigh, input, 1, asynchronous decrement request; acts on its rising edge.
REQ-007 The block SHALL have port SC_RegDOWN_hold_InHigh, input, 1, synchronous pause; decrements are suppressed while high.
REQ-008 The block SHALL have port SC_RegDOWN_data_OutBUS, output, RegDOWN_DATAWIDTH, current count.
REQ-009 The block SHALL have port SC_RegDOWN_expired_OutHigh, output, 1, high while in EXPIRED.
REQ-010 The block SHALL have port SC_RegDOWN_done_OutHigh, output, 1, one-cycle pulse on the RUN->EXPIRED transition.

Function
REQ-011 The block SHALL pass dec through a two-flop synchronizer followed by a third flop, with the edge defined as stage2 AND NOT stage3.
REQ-012 The counter SHALL update on the third rising clock edge after dec rises, provided dec is stable across a setup window; exactly one decrement per dec rising edge.
REQ-013 dec SHALL be high for at least 2 clocks and low for at least 2 clocks between requests; faster toggling is out of spec.
REQ-014 The block SHALL implement FSM states IDLE, RUN and EXPIRED.
REQ-015 In IDLE, count = 0, expired = 0, and edges are ignored.
REQ-016 In every state, load SHALL set count <= data_InBUS and move to RUN if data_InBUS != 0, else to EXPIRED with no done pulse.
REQ-017 load SHALL have priority over a simultaneous edge; that edge is discarded.
REQ-018 In RUN with an edge present and hold = 0, the block SHALL set count <= count - 1.
REQ-019 When the RUN decrement starts from count = 1, the block SHALL set count to 0, enter EXPIRED and assert done for exactly that next cycle.
REQ-020 In RUN with hold = 1, edges SHALL be dropped, not queued; count holds.
REQ-021 In EXPIRED, count SHALL hold at 0 and edges SHALL be ignored; no wrap to all-ones.
REQ-022 Only load or reset SHALL leave EXPIRED.
REQ-023 Arithmetic SHALL be unsigned, RegDOWN_DATAWIDTH bits; a load of all-ones is legal and counts 2^W-1 edges to expiry.
REQ-024 Outputs SHALL be registered or a direct decode of state, with no combinational path from inputs to outputs.

Reset
REQ-025 Asserting reset SHALL immediately force state = IDLE, count = 0, expired = 0, done = 0 and all synchronizer flops = 0.
REQ-026 Reset asserted mid-count SHALL abandon the count; no done pulse is produced.
REQ-027 After reset deasserts, a dec already high SHALL produce one edge (stage3 starts at 0); in IDLE that edge is ignored.

Structure
REQ-028 A shared package sc_reg_pkg SHALL hold the state encoding constants (IDLE = 2'b00, RUN = 2'b01, EXPIRED = 2'b10) and the default width constant 8.
REQ-029 The synchronizer and edge logic SHALL be a sub-module, sc_edge_detect: inputs clock, reset and async level; output one-cycle rise pulse.
REQ-030 Unused state encoding 2'b11 SHALL return to IDLE.

Verification
REQ-031 Reset, load 3, three dec pulses (4 clocks high / 4 low) -> data_Out 3,2,1,0; done is a single-cycle pulse with the 0; expired = 1.
REQ-032 Count 5 in RUN, load 9 on the same cycle an edge is detected -> data_Out = 9, not 8 or 4.
REQ-033 Count 2, hold = 1 across two dec pulses -> count remains 2; hold = 0, one pulse -> 1.
REQ-034 In EXPIRED, five dec pulses -> data_Out stays 0 with no done pulse; load 0 from IDLE -> EXPIRED with done = 0.
REQ-035 Load 200, reset asserted asynchronously mid-clock after 10 decrements -> outputs are 0/IDLE before the next clock edge, and there is no done pulse.
REQ-036 RegDOWN_DATAWIDTH = 4, load 4'hF, 15 pulses -> expires after the 15th pulse with no wrap.
